// File: rtl/bcd_pkg.sv
// Shared segment patterns for the BCD display path.
// All patterns are active low in {g,f,e,d,c,b,a} order.
package bcd_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder.
// Non-decimal codes show a dash so a corrupted counter is visible rather than dark.
module bcd_to_seg7
  import bcd_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_DASH;
    case (bcd)
      4'd0:    seg_n = SEG_0;
      4'd1:    seg_n = SEG_1;
      4'd2:    seg_n = SEG_2;
      4'd3:    seg_n = SEG_3;
      4'd4:    seg_n = SEG_4;
      4'd5:    seg_n = SEG_5;
      4'd6:    seg_n = SEG_6;
      4'd7:    seg_n = SEG_7;
      4'd8:    seg_n = SEG_8;
      4'd9:    seg_n = SEG_9;
      default: seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed common-anode display driver for cascaded BCD counters.
// Snapshots the digits on load, scans one digit per slot with a dark cycle between slots.
module bcd_display_scan
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
)
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic                      load,
  input  logic                      blank_lz,
  output logic [6:0]                seg_n,
  output logic [NUM_DIGITS-1:0]     an_n
);

  localparam int PS_W  = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [PS_W-1:0]          prescaler;
  logic [IDX_W-1:0]         index;
  logic [4*NUM_DIGITS-1:0]  snapshot;
  logic                     tick;

  logic [3:0]               sel_digit;
  logic                     sel_blank;
  logic [NUM_DIGITS-1:0]    sel_onehot;
  logic [NUM_DIGITS-1:0]    blank_mask;
  logic                     zero_run;
  logic [6:0]               dec_seg_n;

  assign tick = (prescaler == PS_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      index     <= '0;
    end else if (tick) begin
      prescaler <= '0;
      index     <= (index == IDX_LAST) ? '0 : index + IDX_W'(1);
    end else begin
      prescaler <= prescaler + PS_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snapshot <= '0;
    end else if (load) begin
      snapshot <= digits_in;
    end
  end

  // A digit is a leading zero when it and every more significant digit is zero;
  // digit 0 always stays lit so the value zero still shows.
  always_comb begin
    blank_mask = '0;
    zero_run   = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run      = zero_run & (snapshot[4*i +: 4] == 4'd0);
      blank_mask[i] = blank_lz & zero_run;
    end
  end

  always_comb begin
    sel_digit  = '0;
    sel_blank  = 1'b0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (index == IDX_W'(i)) begin
        sel_digit     = snapshot[4*i +: 4];
        sel_blank     = blank_mask[i];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  bcd_to_seg7 u_dec (
    .bcd   (sel_digit),
    .seg_n (dec_seg_n)
  );

  // The tick edge drives everything dark for one cycle so the old segment
  // pattern never bleeds onto the next anode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_n <= SEG_OFF;
      an_n  <= '1;
    end else if (tick || sel_blank) begin
      seg_n <= SEG_OFF;
      an_n  <= '1;
    end else begin
      seg_n <= dec_seg_n;
      an_n  <= ~sel_onehot;
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan with NUM_DIGITS=4, SCAN_DIV=4.
// A cycle model pushes the expected outputs of every edge; they are popped after the edge.
module tb_bcd_display_scan;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] digits_in;
  logic        load;
  logic        blank_lz;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;

  exp_t        sb[$];
  int          vectors;
  int          miscompares;

  int          m_ps;
  int          m_idx;
  logic [15:0] m_snap;

  bcd_display_scan #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .digits_in (digits_in),
    .load      (load),
    .blank_lz  (blank_lz),
    .seg_n     (seg_n),
    .an_n      (an_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  task automatic modelReset();
    m_ps   = 0;
    m_idx  = 0;
    m_snap = 16'h0000;
  endtask

  task automatic compare(input string tag, input exp_t obs, input exp_t exp);
    vectors++;
    assert (obs.seg === exp.seg) else begin
      miscompares++;
      $error("[TB] FAIL %s seg_n observed=%h expected=%h", tag, obs.seg, exp.seg);
    end
    vectors++;
    assert (obs.an === exp.an) else begin
      miscompares++;
      $error("[TB] FAIL %s an_n observed=%h expected=%h", tag, obs.an, exp.an);
    end
  endtask

  task automatic checkOutput(input string tag);
    exp_t obs;
    exp_t exp;
    obs.seg = seg_n;
    obs.an  = an_n;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL %s scoreboard empty observed=%h/%h expected=entry", tag, seg_n, an_n);
    end else begin
      exp = sb.pop_front();
      compare(tag, obs, exp);
    end
  endtask

  // Expected outputs are computed from the model state before the edge, then the
  // model advances exactly as the edge will.
  task automatic applyStimulus(input logic [15:0] d, input logic ld, input logic blz,
                               input string tag);
    exp_t e;
    digits_in = d;
    load      = ld;
    blank_lz  = blz;
    e.seg = 7'h7F;
    e.an  = 4'hF;
    if (!rst && m_ps != 3) begin
      if (!(m_idx != 0 && blz && ((m_snap >> (4 * m_idx)) == 16'h0))) begin
        e.seg = ref_seg(m_snap[4*m_idx +: 4]);
        e.an  = ~(4'b0001 << m_idx);
      end
    end
    sb.push_back(e);
    if (!rst) begin
      if (ld) m_snap = d;
      if (m_ps == 3) begin
        m_ps  = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_ps = m_ps + 1;
      end
    end
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic checkNow(input string tag, input logic [6:0] es, input logic [3:0] ea);
    exp_t obs;
    exp_t exp;
    obs.seg = seg_n;
    obs.an  = an_n;
    exp.seg = es;
    exp.an  = ea;
    compare(tag, obs, exp);
  endtask

  initial begin
    int guard;
    logic [15:0] cur;
    logic        cur_blz;
    vectors     = 0;
    miscompares = 0;
    rst       = 1'b1;
    digits_in = 16'h0000;
    load      = 1'b0;
    blank_lz  = 1'b0;
    modelReset();

    #2;
    checkNow("reset_async", 7'h7F, 4'hF);
    repeat (2) applyStimulus(16'h0000, 1'b0, 1'b0, "reset_hold");
    rst = 1'b0;
    applyStimulus(16'h0000, 1'b0, 1'b0, "first_edge");
    checkNow("first_edge_digit0", 7'h40, 4'hE);
    repeat (7) applyStimulus(16'h0000, 1'b0, 1'b0, "idle_scan");

    applyStimulus(16'h1234, 1'b1, 1'b0, "load_1234");
    repeat (20) applyStimulus(16'h1234, 1'b0, 1'b0, "scan_1234");

    repeat (12) applyStimulus(16'h5678, 1'b0, 1'b0, "no_load_hold");

    while (m_ps != 1 && guard < 8) begin
      applyStimulus(16'h5678, 1'b0, 1'b0, "align_mid");
      guard++;
    end
    applyStimulus(16'h9876, 1'b1, 1'b0, "load_mid_slot");
    repeat (12) applyStimulus(16'h9876, 1'b0, 1'b0, "scan_9876");

    applyStimulus(16'h0042, 1'b1, 1'b1, "load_0042");
    repeat (16) applyStimulus(16'h0042, 1'b0, 1'b1, "blank_0042");

    applyStimulus(16'h0000, 1'b1, 1'b1, "load_0000");
    repeat (16) applyStimulus(16'h0000, 1'b0, 1'b1, "blank_0000");
    repeat (16) applyStimulus(16'h0000, 1'b0, 1'b0, "noblank_0000");

    applyStimulus(16'h00A0, 1'b1, 1'b1, "load_00A0");
    repeat (16) applyStimulus(16'h00A0, 1'b0, 1'b1, "dash_00A0");

    guard = 0;
    while (m_ps != 3 && guard < 8) begin
      applyStimulus(16'h00A0, 1'b0, 1'b1, "align_tick");
      guard++;
    end
    applyStimulus(16'h0305, 1'b1, 1'b1, "load_on_tick");
    repeat (16) applyStimulus(16'h0305, 1'b0, 1'b1, "after_tick_load");

    applyStimulus(16'h4321, 1'b1, 1'b0, "load_4321");
    repeat (5) applyStimulus(16'h4321, 1'b0, 1'b0, "pre_reset");
    #2;
    rst = 1'b1;
    #1;
    checkNow("reset_mid_scan", 7'h7F, 4'hF);
    modelReset();
    applyStimulus(16'h4321, 1'b0, 1'b0, "mid_reset_hold");
    rst = 1'b0;
    repeat (8) applyStimulus(16'h4321, 1'b0, 1'b0, "post_reset");

    cur     = 16'h0000;
    cur_blz = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        cur     = 16'($urandom);
        cur_blz = 1'($urandom_range(0, 1));
        applyStimulus(cur, 1'b1, cur_blz, "random_load");
      end else begin
        applyStimulus(16'($urandom), 1'b0, cur_blz, "random_hold");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
